multi_phase_driver: RTL

MULTI_PHASE_DRIVER -- requirements
Module: multi_phase_driver

---
 rtl/multi_phase_driver.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/multi_phase_driver.sv
`default_nettype none
// ============================================================================
// Module   : multi_phase_driver
// Brief    : N-phase half-bridge PWM driver with dead-time insertion, staged
//            duty/high-z loading at period boundaries and per-phase float.
//            Optional macro CENTER_ALIGN_EN selects up/down (centre-aligned)
//            counting; when undefined the counter is edge-aligned only.
// Revision : 1.0 - initial release
// ============================================================================
module multi_phase_driver #(
    parameter int NUM_PHASES    = 3,
    parameter int COUNTER_WIDTH = 10,
    parameter int MAX_COUNTER   = 1000,
    parameter int DUTY_WIDTH    = 9,
    parameter int MAX_DUTY      = 500,
    parameter int DUTY_STEP     = 2,
    parameter int DEAD_TIME     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [NUM_PHASES*DUTY_WIDTH-1:0] duty,
    input  logic [NUM_PHASES-1:0]            high_z,
    input  logic                             load,
    output logic                             load_ack,
    output logic                             period_start,
    output logic [NUM_PHASES-1:0]            pwm_high,
    output logic [NUM_PHASES-1:0]            pwm_low
);

    localparam int                       c_DEAD_W    = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [c_DEAD_W-1:0]      c_DEAD_LOAD = c_DEAD_W'(DEAD_TIME - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_LAST  = COUNTER_WIDTH'(MAX_COUNTER - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_ONE   = COUNTER_WIDTH'(1);
    localparam logic [DUTY_WIDTH-1:0]    c_DUTY_MAX  = DUTY_WIDTH'(MAX_DUTY);

    localparam logic [1:0] c_ST_OFF  = 2'd0;
    localparam logic [1:0] c_ST_HIGH = 2'd1;
    localparam logic [1:0] c_ST_LOW  = 2'd2;
    localparam logic [1:0] c_ST_DEAD = 2'd3;

    logic [COUNTER_WIDTH-1:0] r_counter;
    logic                     r_pending;
    logic                     w_at_boundary;
    logic                     w_boundary;
    logic                     w_transfer;

`ifdef CENTER_ALIGN_EN
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_BOUNDARY = c_CNT_LAST;

    logic r_count_down;

    // Up 0..MAX_COUNTER-1, then down to 1; the peak is the period boundary.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_counter    <= '0;
            r_count_down <= 1'b0;
        end else if (r_count_down) begin
            r_counter <= r_counter - c_CNT_ONE;
            if (r_counter == c_CNT_ONE) begin
                r_count_down <= 1'b0;
            end
        end else if (r_counter == c_CNT_LAST) begin
            r_counter    <= r_counter - c_CNT_ONE;
            r_count_down <= 1'b1;
        end else begin
            r_counter <= r_counter + c_CNT_ONE;
        end
    end
`else
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_BOUNDARY = '0;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_counter <= '0;
        end else if (r_counter == c_CNT_LAST) begin
            r_counter <= '0;
        end else begin
            r_counter <= r_counter + c_CNT_ONE;
        end
    end
`endif

    // While disabled every cycle is a boundary, so staged values still land.
    // A load in the boundary cycle wins: it is staged and waits a period.
    assign w_at_boundary = (r_counter == c_CNT_BOUNDARY);
    assign w_boundary    = !enable || w_at_boundary;
    assign w_transfer    = w_boundary && r_pending && !load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= 1'b0;
            load_ack     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            load_ack     <= w_transfer;
            period_start <= enable && w_at_boundary;
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_transfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
            logic [DUTY_WIDTH-1:0] w_duty_in;
            logic [DUTY_WIDTH-1:0] w_duty_clamped;
            logic [DUTY_WIDTH-1:0] r_stg_duty;
            logic [DUTY_WIDTH-1:0] r_act_duty;
            logic [DUTY_WIDTH-1:0] w_eff_duty;
            logic                  r_stg_hz;
            logic                  r_act_hz;
            logic                  w_eff_hz;
            logic                  w_req;
            logic [1:0]            r_state;
            logic [c_DEAD_W-1:0]   r_dead_cnt;

            assign w_duty_in      = duty[p*DUTY_WIDTH +: DUTY_WIDTH];
            assign w_duty_clamped = (w_duty_in > c_DUTY_MAX) ? c_DUTY_MAX : w_duty_in;

            // Values taking effect this cycle, so the boundary cycle already
            // uses the freshly transferred settings.
            assign w_eff_duty = w_transfer ? r_stg_duty : r_act_duty;
            assign w_eff_hz   = w_transfer ? r_stg_hz   : r_act_hz;
            assign w_req      = (32'(r_counter) < (32'(w_eff_duty) * 32'(DUTY_STEP)));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stg_duty <= '0;
                    r_act_duty <= '0;
                    r_stg_hz   <= 1'b1;
                    r_act_hz   <= 1'b1;
                end else begin
                    if (load) begin
                        r_stg_duty <= w_duty_clamped;
                        r_stg_hz   <= high_z[p];
                    end
                    r_act_duty <= w_eff_duty;
                    r_act_hz   <= w_eff_hz;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state    <= c_ST_OFF;
                    r_dead_cnt <= '0;
                end else if (!enable || w_eff_hz) begin
                    r_state <= c_ST_OFF;
                end else begin
                    case (r_state)
                        c_ST_OFF: begin
                            r_state    <= c_ST_DEAD;
                            r_dead_cnt <= c_DEAD_LOAD;
                        end
                        c_ST_HIGH: begin
                            if (!w_req) begin
                                r_state    <= c_ST_DEAD;
                                r_dead_cnt <= c_DEAD_LOAD;
                            end
                        end
                        c_ST_LOW: begin
                            if (w_req) begin
                                r_state    <= c_ST_DEAD;
                                r_dead_cnt <= c_DEAD_LOAD;
                            end
                        end
                        default: begin
                            if (r_dead_cnt == '0) begin
                                r_state <= w_req ? c_ST_HIGH : c_ST_LOW;
                            end else begin
                                r_dead_cnt <= r_dead_cnt - 1'b1;
                            end
                        end
                    endcase
                end
            end

            assign pwm_high[p] = (r_state == c_ST_HIGH);
            assign pwm_low[p]  = (r_state == c_ST_LOW);
        end
    endgenerate

endmodule
`default_nettype wire
